// File: rtl/cache_axi_pkg.sv
// Shared types and AXI constants for the cache line <-> AXI4 bridge.
package cache_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } RdStateType;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } WrStateType;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam int         LINE_BEATS     = 4;
  localparam logic [7:0] LINE_LEN       = 8'd3;

endpackage

// File: rtl/cache_axi_wr_channel.sv
// Writeback channel: latches a 128-bit line and emits it as one AW + 4-beat W burst,
// then waits for B. Busy flag and line tag feed the top-level read-after-write guard.
//
// state  | meaning
// W_IDLE | ready for a writeback (wr_rdy=1)
// W_AW   | address phase, awvalid held until awready
// W_DATA | four W beats, beat index advances on wvalid&wready
// W_RESP | bready=1, wr_valid pulses with the bvalid handshake
module cache_axi_wr_channel
  import cache_axi_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_wr_req,
  input  logic [27:0]  i_wr_line,
  input  logic [127:0] i_wr_data,
  output logic         o_wr_rdy,
  output logic         o_wr_valid,
  output logic [31:0]  o_awaddr,
  output logic         o_awvalid,
  input  logic         i_awready,
  output logic [31:0]  o_wdata,
  output logic         o_wlast,
  output logic         o_wvalid,
  input  logic         i_wready,
  input  logic         i_bvalid,
  output logic         o_bready,
  output logic         o_busy,
  output logic [27:0]  o_line_tag
);

  WrStateType   r_state;
  WrStateType   w_state_nxt;
  logic [27:0]  r_line;
  logic [127:0] r_buf;
  logic [1:0]   r_beat;
  logic         w_accept;
  logic         w_beat_done;

  assign o_wr_rdy    = i_resetn && (r_state == W_IDLE);
  assign w_accept    = i_wr_req && o_wr_rdy;
  assign w_beat_done = (r_state == W_DATA) && i_wready;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= W_IDLE;
      r_line  <= '0;
      r_buf   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_line <= i_wr_line;
        r_buf  <= i_wr_data;
        r_beat <= '0;
      end else if (w_beat_done) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_wr_valid  = 1'b0;
    case (r_state)
      W_IDLE: if (w_accept) w_state_nxt = W_AW;
      W_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        o_wvalid = 1'b1;
        if (i_wready && (r_beat == 2'd3)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        o_bready = 1'b1;
        // wr_valid rides the B handshake so the writer is free the very next cycle
        if (i_bvalid) begin
          o_wr_valid  = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign o_awaddr   = {r_line, 4'h0};
  assign o_wdata    = r_buf[{r_beat, 5'b0} +: 32];
  assign o_wlast    = (r_state == W_DATA) && (r_beat == 2'd3);
  assign o_busy     = (r_state != W_IDLE);
  assign o_line_tag = r_line;

endmodule

// File: rtl/cache_line_axi_bridge.sv
// Cache line bus slave to AXI4 master: 128-bit refills/writebacks as 4-beat INCR bursts.
// Define RAW_LINE_CHECK_EN to hold off refills of a line whose writeback is still in flight.
//
// state  | meaning
// R_IDLE | ready for a refill (rd_rdy=1)
// R_AR   | address phase, arvalid held until arready
// R_DATA | collect R beats into ret_buf, rlast ends the burst
// R_DONE | ret_valid for one cycle with the assembled line
module cache_line_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int RD_ID    = 0,
  parameter int WR_ID    = 1
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_rd_req,
  input  logic [31:0]         i_rd_addr,
  output logic                o_rd_rdy,
  output logic                o_ret_valid,
  output logic [127:0]        o_ret_data,
  input  logic                i_wr_req,
  input  logic [31:0]         i_wr_addr,
  input  logic [127:0]        i_wr_data,
  output logic                o_wr_rdy,
  output logic                o_wr_valid,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [31:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [31:0]         o_wdata,
  output logic [3:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  RdStateType   r_rd_state;
  RdStateType   w_rd_state_nxt;
  logic [27:0]  r_rd_line;
  logic [127:0] r_ret_buf;
  logic [1:0]   r_rd_beat;
  logic         w_rd_accept;
  logic         w_raw_block;
  logic         w_wr_busy;
  logic [27:0]  w_wr_line;
  logic         w_unused;

  // ids, status and sub-line address bits carry no information for a full-line bridge
  assign w_unused = ^{i_rd_addr[3:0], i_wr_addr[3:0], i_rid, i_rresp, i_bid, i_bresp};

`ifdef RAW_LINE_CHECK_EN
  assign w_raw_block = (w_wr_busy && (i_rd_addr[31:4] == w_wr_line)) ||
                       (i_wr_req && o_wr_rdy && (i_rd_addr[31:4] == i_wr_addr[31:4]));
`else
  logic w_unused_raw;
  assign w_unused_raw = ^{w_wr_busy, w_wr_line};
  assign w_raw_block  = 1'b0;
`endif

  assign o_rd_rdy    = i_resetn && (r_rd_state == R_IDLE) && !w_raw_block;
  assign w_rd_accept = i_rd_req && o_rd_rdy;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rd_state <= R_IDLE;
      r_rd_line  <= '0;
      r_ret_buf  <= '0;
      r_rd_beat  <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_rd_accept) begin
        r_rd_line <= i_rd_addr[31:4];
        r_rd_beat <= '0;
      end else if ((r_rd_state == R_DATA) && i_rvalid) begin
        r_ret_buf[{r_rd_beat, 5'b0} +: 32] <= i_rdata;
        r_rd_beat <= r_rd_beat + 2'd1;
      end
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    o_arvalid      = 1'b0;
    o_rready       = 1'b0;
    o_ret_valid    = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_rd_accept) w_rd_state_nxt = R_AR;
      R_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        o_rready = 1'b1;
        if (i_rvalid && i_rlast) w_rd_state_nxt = R_DONE;
      end
      R_DONE: begin
        o_ret_valid    = 1'b1;
        w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign o_ret_data = r_ret_buf;
  assign o_arid     = ID_WIDTH'(RD_ID);
  assign o_araddr   = {r_rd_line, 4'h0};
  assign o_arlen    = LINE_LEN;
  assign o_arsize   = AXI_SIZE_4B;
  assign o_arburst  = AXI_BURST_INCR;

  assign o_awid     = ID_WIDTH'(WR_ID);
  assign o_awlen    = LINE_LEN;
  assign o_awsize   = AXI_SIZE_4B;
  assign o_awburst  = AXI_BURST_INCR;
  assign o_wstrb    = 4'hF;

  cache_axi_wr_channel u_wr_channel (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_wr_req   (i_wr_req),
    .i_wr_line  (i_wr_addr[31:4]),
    .i_wr_data  (i_wr_data),
    .o_wr_rdy   (o_wr_rdy),
    .o_wr_valid (o_wr_valid),
    .o_awaddr   (o_awaddr),
    .o_awvalid  (o_awvalid),
    .i_awready  (i_awready),
    .o_wdata    (o_wdata),
    .o_wlast    (o_wlast),
    .o_wvalid   (o_wvalid),
    .i_wready   (i_wready),
    .i_bvalid   (i_bvalid),
    .o_bready   (o_bready),
    .o_busy     (w_wr_busy),
    .o_line_tag (w_wr_line)
  );

endmodule
